// File: rtl/clb_config_loader_pkg.sv
// Shared definitions for the fabric configuration loader.
//   - Default word and counter widths. The SoC bridge and the fabric
//     top-level bench reuse these values.
//   - Loader FSM state encoding:
//     IDLE=0, LOAD=1, SHIFT=2, SET=3, DONE=4.
package clb_config_loader_pkg;

    localparam int DEF_WORD_W = 32;
    localparam int DEF_CNT_W  = 20;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_SET   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/config_word_serializer.sv
// Parallel-load, serial-out configuration word register with bit counter.
// The register shifts right, so bit 0 of a loaded word is presented first.
//   clk, rst   : clock and synchronous active-high reset
//   load       : capture load_data and load_bits (takes priority over shift)
//   shift      : advance one bit and decrement the bit counter
//   load_data  : configuration word to serialise
//   load_bits  : number of valid bits in load_data (1..WORD_W)
//   data_bit   : current serial bit (register LSB)
//   last_bit   : exactly one valid bit remains in the register
//   empty      : no valid bits remain in the register
module config_word_serializer
    import clb_config_loader_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int BCNT_W = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] load_data,
    input  logic [BCNT_W-1:0] load_bits,
    output logic              data_bit,
    output logic              last_bit,
    output logic              empty
);

    logic [WORD_W-1:0] sreg_reg;
    logic [BCNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg_reg  <= '0;
            count_reg <= '0;
        end else if (load) begin
            sreg_reg  <= load_data;
            count_reg <= load_bits;
        end else if (shift) begin
            sreg_reg <= sreg_reg >> 1;
            // Hold at zero instead of wrapping if shift is issued while empty.
            if (count_reg != '0) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    assign data_bit = sreg_reg[0];
    assign last_bit = (count_reg == BCNT_W'(1));
    assign empty    = (count_reg == '0);

endmodule

// File: rtl/clb_config_loader.sv
// Upstream driver of the fabric configuration shift chain.
//
// Function
//   Accepts configuration words on a valid/ready stream.
//   Serialises chain_len bits, LSB-first, into the chain head.
//   Pulses set_out for one cycle after the last bit, then pulses done.
//
// Ports
//   clk, rst     : clock and synchronous active-high reset
//   start        : begin a load; honoured only when idle
//   chain_len    : number of bits to shift; sampled when start is accepted
//   word_data    : configuration word; bit 0 is shifted first
//   word_valid   : word_data valid
//   word_ready   : loader accepts a word this cycle
//   cen          : chain shift enable; one bit advances per high cycle
//   shift_out    : serial data to the chain head; forced to 0 when cen=0
//   set_out      : one-cycle configuration latch pulse to the tiles
//   busy         : high in every state except IDLE
//   done         : one-cycle pulse when a load completes
//
// Output timing
//   All control outputs are registered from the next-state value.
//   shift_out combines two registers only.
//   No output has a combinational path from an input.
module clb_config_loader
    import clb_config_loader_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  chain_len,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              cen,
    output logic              shift_out,
    output logic              set_out,
    output logic              busy,
    output logic              done
);

    localparam int BCNT_W = $clog2(WORD_W + 1);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  remaining_reg, remaining_next;
    logic              word_ready_reg, cen_reg, set_reg, busy_reg, done_reg;

    logic              ser_load, ser_shift;
    logic              ser_bit, ser_last, ser_empty;
    logic [BCNT_W-1:0] word_bits;

    // Bits to take from the next word: a full word, or whatever is left of
    // the chain for the final partial word (its high bits are never shifted).
    always_comb begin
        if (remaining_reg >= CNT_W'(WORD_W)) begin
            word_bits = BCNT_W'(WORD_W);
        end else begin
            word_bits = BCNT_W'(remaining_reg);
        end
    end

    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        ser_load       = 1'b0;
        ser_shift      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    remaining_next = chain_len;
                    state_next     = (chain_len == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                // word_ready is high throughout LOAD, so valid alone completes the handshake.
                if (word_valid) begin
                    ser_load   = 1'b1;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                ser_shift = 1'b1;
                // Test for the last bit before decrementing so the counter never wraps.
                if (remaining_reg <= CNT_W'(1)) begin
                    remaining_next = '0;
                    state_next     = ST_SET;
                end else begin
                    remaining_next = remaining_reg - 1'b1;
                    if (ser_last || ser_empty) begin
                        state_next = ST_LOAD;
                    end
                end
            end
            ST_SET:  state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            remaining_reg  <= '0;
            word_ready_reg <= 1'b0;
            cen_reg        <= 1'b0;
            set_reg        <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            remaining_reg  <= remaining_next;
            word_ready_reg <= (state_next == ST_LOAD);
            cen_reg        <= (state_next == ST_SHIFT);
            set_reg        <= (state_next == ST_SET);
            busy_reg       <= (state_next != ST_IDLE);
            done_reg       <= (state_next == ST_DONE);
        end
    end

    config_word_serializer #(
        .WORD_W (WORD_W),
        .BCNT_W (BCNT_W)
    ) u_serializer (
        .clk       (clk),
        .rst       (rst),
        .load      (ser_load),
        .shift     (ser_shift),
        .load_data (word_data),
        .load_bits (word_bits),
        .data_bit  (ser_bit),
        .last_bit  (ser_last),
        .empty     (ser_empty)
    );

    assign word_ready = word_ready_reg;
    assign cen        = cen_reg;
    assign shift_out  = cen_reg & ser_bit;
    assign set_out    = set_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;

endmodule

// File: tb/tb_clb_config_loader.sv
// Self-checking bench for clb_config_loader.
// Covers directed loads of 8, 40, 64 and 0 bits.
// Covers a start request during SHIFT and a reset in the middle of a load.
// Finishes with randomised loads using random words and random valid stalls.
// Expected bit streams and cycle timings come from a word-queue model:
// the chain sees the first N bits of the concatenated words, LSB-first.
module tb_clb_config_loader;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 20;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [CNT_W-1:0]  chain_len;
    logic [WORD_W-1:0] word_data;
    logic              word_valid;
    logic              word_ready, cen, shift_out, set_out, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WORD_W-1:0] wq[$];
    int                stall_q[$];

    always #5 clk = ~clk;

    clb_config_loader #(
        .WORD_W (WORD_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .chain_len  (chain_len),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .cen        (cen),
        .shift_out  (shift_out),
        .set_out    (set_out),
        .busy       (busy),
        .done       (done)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Run one load of n bits using words from wq.
    // stall_q[i] is the number of valid-low LOAD cycles placed before word i.
    // restart_at >= 0: pulse start (chain_len=5) once the cen count reaches restart_at.
    // abort_at >= 0: assert rst once the cen count reaches abort_at.
    task automatic do_load(input string name, input int n, input int restart_at, input int abort_at);
        int nwords     = (n + WORD_W - 1) / WORD_W;
        int stall_sum  = 0;
        int exp_len;
        int budget;
        int widx       = 0;
        int stall_left;
        bit pending    = 0;
        bit finished   = 0;
        bit restarted  = 0;
        int cen_cnt    = 0;
        int set_cnt    = 0;
        int done_cnt   = 0;
        int wr_cnt     = 0;
        int set_cyc    = -1;
        int done_cyc   = -1;
        int last_cen   = -1;
        int sho_bad    = 0;
        int busy_bad   = 0;
        int post_set   = 0;
        logic [WORD_W-1:0] w;
        logic exp_bits[$];
        logic got_bits[$];

        for (int i = 0; i < n; i++) begin
            w = wq[i / WORD_W];
            exp_bits.push_back(w[i % WORD_W]);
        end
        for (int i = 0; i < nwords; i++) stall_sum += stall_q[i];
        exp_len    = nwords + stall_sum + n;
        budget     = exp_len + 20;
        stall_left = (stall_q.size() > 0) ? stall_q[0] : 0;

        @(negedge clk);
        chain_len  = CNT_W'(n);
        start      = 1'b1;
        word_valid = 1'b0;

        for (int cyc = 1; cyc <= budget && !finished; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (pending) begin
                widx++;
                stall_left = (widx < stall_q.size()) ? stall_q[widx] : 0;
                pending    = 0;
            end
            if (!cen && shift_out) sho_bad++;
            if (!busy) busy_bad++;
            if (cen) begin
                got_bits.push_back(shift_out);
                cen_cnt++;
                last_cen = cyc;
            end
            if (set_out) begin
                set_cnt++;
                set_cyc = cyc;
            end
            if (word_ready) wr_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                finished = 1;
            end

            if (abort_at >= 0 && cen && cen_cnt == abort_at) begin
                rst        = 1'b1;
                word_valid = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                check_eq({name, "_abort_outputs"},
                         {word_ready, cen, shift_out, set_out, busy, done}, 6'b0);
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    if (set_out || busy) post_set++;
                end
                check_eq({name, "_abort_no_set"}, set_cnt + post_set, 0);
                $display("load %s: n=%0d aborted after %0d cen cycles", name, n, cen_cnt);
                return;
            end

            if (restart_at >= 0 && !restarted && cen && cen_cnt == restart_at) begin
                start     = 1'b1;
                chain_len = CNT_W'(5);
                restarted = 1;
            end

            if (!finished) begin
                if (word_ready) begin
                    if (stall_left > 0) begin
                        word_valid = 1'b0;
                        stall_left--;
                    end else begin
                        word_valid = 1'b1;
                        word_data  = (widx < wq.size()) ? wq[widx] : WORD_W'($urandom);
                        pending    = 1;
                    end
                end else begin
                    // Outside LOAD the stream may toggle freely; the loader must ignore it.
                    word_valid = 1'($urandom_range(0, 1));
                    word_data  = WORD_W'($urandom);
                end
            end
        end

        word_valid = 1'b0;
        check_eq({name, "_timeout"}, finished, 1);
        check_eq({name, "_cen_count"}, cen_cnt, n);
        check_eq({name, "_bit_count"}, got_bits.size(), exp_bits.size());
        for (int i = 0; i < got_bits.size() && i < exp_bits.size(); i++) begin
            check_eq($sformatf("%s_bit%0d", name, i), got_bits[i], exp_bits[i]);
        end
        check_eq({name, "_words_taken"}, widx, nwords);
        check_eq({name, "_set_count"}, set_cnt, (n > 0) ? 1 : 0);
        check_eq({name, "_done_cycle"}, done_cyc, (n > 0) ? exp_len + 2 : 1);
        if (n > 0) begin
            check_eq({name, "_set_cycle"}, set_cyc, exp_len + 1);
            check_eq({name, "_set_after_last_cen"}, last_cen, set_cyc - 1);
        end else begin
            check_eq({name, "_no_word_ready"}, wr_cnt, 0);
        end
        check_eq({name, "_shift_out_gated"}, sho_bad, 0);
        check_eq({name, "_busy_held"}, busy_bad, 0);

        @(negedge clk);
        check_eq({name, "_idle_after"}, {busy, done, cen, set_out, word_ready}, 5'b0);
        $display("load %s: n=%0d words=%0d stalls=%0d set@%0d done@%0d", name, n, nwords,
                 stall_sum, set_cyc, done_cyc);
    endtask

    task automatic fill_random(input int n, input int max_stall);
        int nw = (n + WORD_W - 1) / WORD_W;
        wq.delete();
        stall_q.delete();
        for (int i = 0; i < nw; i++) begin
            wq.push_back(WORD_W'($urandom));
            stall_q.push_back($urandom_range(0, max_stall));
        end
    endtask

    initial begin
        int n;
        rst        = 1'b1;
        start      = 1'b0;
        chain_len  = '0;
        word_data  = '0;
        word_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_outputs", {word_ready, cen, shift_out, set_out, busy, done}, 6'b0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_outputs", {word_ready, cen, shift_out, set_out, busy, done}, 6'b0);

        wq = '{32'h0000_00A5};
        stall_q = '{0};
        do_load("len8", 8, -1, -1);

        wq = '{32'hFFFF_FFFF, 32'h0000_00AA};
        stall_q = '{0, 3};
        do_load("len40_stall", 40, -1, -1);

        fill_random(64, 0);
        do_load("len64", 64, -1, -1);

        wq.delete();
        stall_q.delete();
        do_load("len0", 0, -1, -1);

        fill_random(20, 1);
        do_load("restart", 20, 3, -1);

        fill_random(40, 0);
        do_load("abort", 40, -1, 10);
        fill_random(40, 0);
        do_load("after_abort", 40, -1, -1);

        for (int t = 0; t < 8; t++) begin
            n = $urandom_range(1, 100);
            fill_random(n, 3);
            do_load($sformatf("rand%0d", t), n, -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
